// File: rtl/ext_vram_arbiter.sv
`default_nettype none
//==============================================================================
// ext_vram_arbiter: shares the 32 KB ext-video SRAM between the video fetcher
// (phase 0) and Z80 accesses to 0x8000-0xFFFF (phases 1-3).  Rev 1.0
//==============================================================================
module ext_vram_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_EN     = 1
) (
  input  logic              CLK_14MHZ,
  input  logic              CPU_RESET,
  input  logic              CPU_MREQ,
  input  logic              CPU_RD,
  input  logic              CPU_WR,
  input  logic              CPU_RFSH,
  input  logic [15:0]       A,
  input  logic [7:0]        D_IN,
  input  logic [7:0]        VD_IN,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [ADDR_W-1:0] VA,
  output logic              VWR,
  output logic [7:0]        VD_OUT,
  output logic              vd_oe,
  output logic [7:0]        D_OUT,
  output logic              d_oe,
  output logic              CPU_WAIT,
  output logic [7:0]        vid_data,
  output logic              vid_stb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEND = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             ph;
  logic [1:0]             state;
  logic [1:0]             acc_cnt;
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   req_raw;
  logic                   req;
  logic                   req_wr;
  logic                   acc_wr;
  logic                   wait_q;
  logic                   vid_slot;

  assign req_raw  = ~CPU_MREQ & CPU_RFSH & A[15] & (~CPU_RD | ~CPU_WR);
  assign req      = req_sync[SYNC_STAGES-1];
  assign req_wr   = wr_sync[SYNC_STAGES-1];
  assign CPU_WAIT = (WAIT_EN != 0) ? wait_q : 1'b1;

  always_ff @(posedge CLK_14MHZ or negedge CPU_RESET) begin
    if (!CPU_RESET) begin
      ph       <= 2'd0;
      state    <= S_IDLE;
      acc_cnt  <= 2'd0;
      req_sync <= '0;
      wr_sync  <= '0;
      acc_wr   <= 1'b0;
      wait_q   <= 1'b1;
      vid_slot <= 1'b0;
      VA       <= '0;
      VWR      <= 1'b1;
      VD_OUT   <= 8'h00;
      vd_oe    <= 1'b0;
      D_OUT    <= 8'h00;
      d_oe     <= 1'b0;
      vid_data <= 8'h00;
      vid_stb  <= 1'b0;
    end else begin
      ph <= ph + 2'd1;

      req_sync[0] <= req_raw;
      wr_sync[0]  <= ~CPU_WR;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        req_sync[i] <= req_sync[i-1];
        wr_sync[i]  <= wr_sync[i-1];
      end

      // Video address is set up on the edge entering phase 0, data captured on the edge leaving it.
      vid_slot <= (ph == 2'd3) && vid_active;
      if (ph == 2'd3 && vid_active) begin
        VA <= vid_addr;
      end
      vid_stb <= 1'b0;
      if (ph == 2'd0 && vid_slot) begin
        vid_data <= VD_IN;
        vid_stb  <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (req) begin
            state  <= S_PEND;
            wait_q <= 1'b0;
          end
        end
        S_PEND: begin
          if (!req) begin
            state  <= S_IDLE;
            wait_q <= 1'b1;
          end else if (ph == 2'd0) begin
            state   <= S_ACC;
            acc_cnt <= 2'd0;
            acc_wr  <= req_wr;
            VA      <= ADDR_W'(A[14:0]);
            VD_OUT  <= D_IN;
            vd_oe   <= req_wr;
          end
        end
        S_ACC: begin
          if (!req) begin
            state  <= S_IDLE;
            VWR    <= 1'b1;
            vd_oe  <= 1'b0;
            wait_q <= 1'b1;
          end else begin
            acc_cnt <= acc_cnt + 2'd1;
            case (acc_cnt)
              2'd0: begin
                VWR    <= ~acc_wr;
                VA     <= ADDR_W'(A[14:0]);
                VD_OUT <= D_IN;
              end
              2'd1: begin
                VWR    <= 1'b1;
                VA     <= ADDR_W'(A[14:0]);
                VD_OUT <= D_IN;
              end
              default: begin
                // Leaving phase 3: the access is complete and the video slot follows.
                state  <= S_DONE;
                VWR    <= 1'b1;
                vd_oe  <= 1'b0;
                wait_q <= 1'b1;
                if (!acc_wr) begin
                  D_OUT <= VD_IN;
                  d_oe  <= 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          if (!req) begin
            state <= S_IDLE;
            d_oe  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_vram_arbiter.sv
`default_nettype none
// Directed bench for ext_vram_arbiter: video slot, CPU write/read, negatives, abort, reset.
module tb_ext_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mreq, rd, wr, rfsh;
  logic [15:0] a;
  logic [7:0]  d_in, vd_in;
  logic        vid_active;
  logic [14:0] vid_addr;
  logic [14:0] va;
  logic        vwr, vd_oe, d_oe, cpu_wait, vid_stb;
  logic [7:0]  vd_out, d_out, vid_data;

  int checks = 0;
  int errors = 0;
  int cyc;

  ext_vram_arbiter dut (
    .CLK_14MHZ (clk),
    .CPU_RESET (rst_n),
    .CPU_MREQ  (mreq),
    .CPU_RD    (rd),
    .CPU_WR    (wr),
    .CPU_RFSH  (rfsh),
    .A         (a),
    .D_IN      (d_in),
    .VD_IN     (vd_in),
    .vid_active(vid_active),
    .vid_addr  (vid_addr),
    .VA        (va),
    .VWR       (vwr),
    .VD_OUT    (vd_out),
    .vd_oe     (vd_oe),
    .D_OUT     (d_out),
    .d_oe      (d_oe),
    .CPU_WAIT  (cpu_wait),
    .vid_data  (vid_data),
    .vid_stb   (vid_stb)
  );

  always #5 clk = ~clk;

  // Clock count since reset release; the phase during the current clock is cyc % 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic align_ph0();
    while (cyc % 4 != 0) step();
  endtask

  task automatic bus_idle();
    mreq = 1'b1; rd = 1'b1; wr = 1'b1; rfsh = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_vwr"},  16'(vwr),      16'h1);
    check_val({tag, "_wait"}, 16'(cpu_wait), 16'h1);
    check_val({tag, "_vdoe"}, 16'(vd_oe),    16'h0);
    check_val({tag, "_doe"},  16'(d_oe),     16'h0);
    check_val({tag, "_stb"},  16'(vid_stb),  16'h0);
    check_val({tag, "_va"},   16'(va),       16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    bus_idle();
    a = 16'h0000; d_in = 8'h00; vd_in = 8'h00;
    vid_active = 1'b0; vid_addr = 15'h0000;

    // Reset held while strobes toggle randomly
    for (int i = 0; i < 8; i++) begin
      step();
      mreq = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom); rfsh = 1'($urandom);
      a = 16'($urandom); vid_active = 1'($urandom);
      vd_in = 8'($urandom); d_in = 8'($urandom);
      #1 check_reset_outputs("rst_hold");
    end
    check_val("rst_dout",    16'(d_out),    16'h00);
    check_val("rst_viddata", 16'(vid_data), 16'h00);

    // Video only
    step();
    bus_idle();
    a = 16'h0000;
    vid_active = 1'b1; vid_addr = 15'h1234; vd_in = 8'hA5;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check_val("vid_stb", 16'(vid_stb), 16'((k >= 5) && (k % 4 == 1)));
      if (k % 4 == 0) check_val("vid_va", 16'(va), 16'h1234);
      if (k == 5)     check_val("vid_data", 16'(vid_data), 16'h00A5);
      check_val("vid_wait", 16'(cpu_wait), 16'h1);
    end

    // CPU write 0x5A -> 0xC001, synced request lands in phase 2
    align_ph0();
    a = 16'hC001; d_in = 8'h5A; mreq = 1'b0; wr = 1'b0;
    step(); check_val("wr_j1_wait", 16'(cpu_wait), 16'h1);
    step(); check_val("wr_j2_wait", 16'(cpu_wait), 16'h1);
    step(); check_val("wr_j3_wait", 16'(cpu_wait), 16'h0);
            check_val("wr_j3_vwr",  16'(vwr),      16'h1);
    step(); check_val("wr_j4_va",   16'(va),       16'h1234);
            check_val("wr_j4_vwr",  16'(vwr),      16'h1);
    step(); check_val("wr_j5_va",   16'(va),       16'h4001);
            check_val("wr_j5_vdoe", 16'(vd_oe),    16'h1);
            check_val("wr_j5_vdout",16'(vd_out),   16'h005A);
            check_val("wr_j5_vwr",  16'(vwr),      16'h1);
    step(); check_val("wr_j6_vwr",  16'(vwr),      16'h0);
            check_val("wr_j6_va",   16'(va),       16'h4001);
    step(); check_val("wr_j7_vwr",  16'(vwr),      16'h1);
            check_val("wr_j7_va",   16'(va),       16'h4001);
            check_val("wr_j7_wait", 16'(cpu_wait), 16'h0);
    step(); check_val("wr_j8_wait", 16'(cpu_wait), 16'h1);
            check_val("wr_j8_vdoe", 16'(vd_oe),    16'h0);
            check_val("wr_j8_va",   16'(va),       16'h1234);
    bus_idle();
    for (int k = 0; k < 4; k++) begin
      step(); check_val("wr_after_doe", 16'(d_oe), 16'h0);
    end

    // CPU read of 0x8000, SRAM returns 0x3C
    align_ph0();
    a = 16'h8000; vd_in = 8'h3C; mreq = 1'b0; rd = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j == 3 || j == 7) check_val("rd_wait_low", 16'(cpu_wait), 16'h0);
      if (j == 5) begin
        check_val("rd_j5_va",   16'(va),    16'h0000);
        check_val("rd_j5_vdoe", 16'(vd_oe), 16'h0);
      end
      if (j == 6) check_val("rd_j6_vwr", 16'(vwr), 16'h1);
      if (j == 8) begin
        check_val("rd_j8_dout", 16'(d_out),    16'h003C);
        check_val("rd_j8_wait", 16'(cpu_wait), 16'h1);
      end
      if (j >= 8) check_val("rd_doe_hold", 16'(d_oe), 16'h1);
      if (j == 10) bus_idle();
    end
    step(); check_val("rd_doe_drop", 16'(d_oe),     16'h0);
            check_val("rd_wait_end", 16'(cpu_wait), 16'h1);

    // Negative: A15=0 read, then refresh cycle at 0x8000
    align_ph0();
    vd_in = 8'hA5;
    a = 16'h4000; mreq = 1'b0; rd = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      check_val("neg_a15_wait", 16'(cpu_wait), 16'h1);
      check_val("neg_a15_va",   16'(va),       16'h1234);
    end
    bus_idle();
    align_ph0();
    a = 16'h8000; mreq = 1'b0; rd = 1'b0; rfsh = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      check_val("neg_rfsh_wait", 16'(cpu_wait), 16'h1);
      check_val("neg_rfsh_va",   16'(va),       16'h1234);
    end
    bus_idle();

    // Abort: write request withdrawn so the synced request falls during ACC phase 2
    align_ph0();
    a = 16'hC001; d_in = 8'h5A; mreq = 1'b0; wr = 1'b0;
    for (int j = 1; j <= 4; j++) step();
    bus_idle();
    step(); check_val("ab_j5_vdoe", 16'(vd_oe),    16'h1);
    step(); check_val("ab_j6_vwr",  16'(vwr),      16'h0);
    step(); check_val("ab_j7_vwr",  16'(vwr),      16'h1);
            check_val("ab_j7_wait", 16'(cpu_wait), 16'h1);
            check_val("ab_j7_vdoe", 16'(vd_oe),    16'h0);
    step(); check_val("ab_j8_dout", 16'(d_out),    16'h003C);
            check_val("ab_j8_doe",  16'(d_oe),     16'h0);
    for (int j = 0; j < 4; j++) begin
      step(); check_val("ab_idle_wait", 16'(cpu_wait), 16'h1);
    end

    // Reset asserted while VWR is low mid-access
    align_ph0();
    a = 16'hC001; d_in = 8'h5A; mreq = 1'b0; wr = 1'b0;
    for (int j = 1; j <= 6; j++) step();
    check_val("rstacc_pre_vwr", 16'(vwr), 16'h0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_acc");
    check_val("rst_acc_vdout",   16'(vd_out),   16'h00);
    check_val("rst_acc_dout",    16'(d_out),    16'h00);
    check_val("rst_acc_viddata", 16'(vid_data), 16'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
